// File: rtl/arbitro_de_ocupacion.sv
// Buffers lane entry/exit pulses per source and grants one BCD occupancy update per cycle.
// Define PRIORIDAD_SALIDA_EN for fixed exit-first priority instead of round-robin.
module arbitro_de_ocupacion #(
    parameter int unsigned CAPACIDAD = 99,
    parameter int unsigned PEND_MAX  = 3
) (
    input  logic       clk,
    input  logic       reset_btn,
    input  logic       ent_a,
    input  logic       sal_a,
    input  logic       ent_b,
    input  logic       sal_b,
    output logic       inc,
    output logic       dec,
    output logic [3:0] unidades,
    output logic [3:0] decenas,
    output logic       lleno,
    output logic       vacio,
    output logic       rechazo,
    output logic       err_desborde
);

    localparam logic [1:0] PendMax = 2'(PEND_MAX);
    localparam logic [6:0] Cap     = 7'(CAPACIDAD);

    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_idx;

    logic [1:0] pend_q [4];
    logic [1:0] pend_d [4];
    logic       err_q, err_d;
    logic [3:0] unidades_q, unidades_d;
    logic [3:0] decenas_q, decenas_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       rechazo_q, rechazo_d;
    logic [6:0] ocupacion;

    assign req = {sal_b, ent_b, sal_a, ent_a};

`ifdef PRIORIDAD_SALIDA_EN
    // Exits first so they free space before queued entries are tested against lleno.
    always_comb begin
        gnt_vld = 1'b1;
        gnt_idx = 2'd0;
        if (pend_q[1] != 2'd0) begin
            gnt_idx = 2'd1;
        end else if (pend_q[3] != 2'd0) begin
            gnt_idx = 2'd3;
        end else if (pend_q[0] != 2'd0) begin
            gnt_idx = 2'd0;
        end else if (pend_q[2] != 2'd0) begin
            gnt_idx = 2'd2;
        end else begin
            gnt_vld = 1'b0;
        end
    end
`else
    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        logic [1:0] cand;
        cand    = 2'd0;
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_vld && pend_q[cand] != 2'd0) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign ptr_d = gnt_vld ? gnt_idx + 2'd1 : ptr_q;

    always_ff @(posedge clk) begin
        if (reset_btn) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        gnt = 4'b0000;
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // A request hitting a saturated counter is lost and latches the overflow flag.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < 4; i++) begin
            pend_d[i] = pend_q[i];
            if (req[i] && !gnt[i]) begin
                if (pend_q[i] == PendMax) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 2'd1;
                end
            end else if (gnt[i] && !req[i]) begin
                pend_d[i] = pend_q[i] - 2'd1;
            end
        end
    end

    assign ocupacion = 7'(decenas_q) * 7'd10 + 7'(unidades_q);

    // Even indices are entries, odd indices are exits.
    always_comb begin
        unidades_d = unidades_q;
        decenas_d  = decenas_q;
        inc_d      = 1'b0;
        dec_d      = 1'b0;
        rechazo_d  = 1'b0;
        if (gnt_vld) begin
            if (!gnt_idx[0]) begin
                if (ocupacion < Cap) begin
                    inc_d = 1'b1;
                    if (unidades_q == 4'd9) begin
                        unidades_d = 4'd0;
                        decenas_d  = decenas_q + 4'd1;
                    end else begin
                        unidades_d = unidades_q + 4'd1;
                    end
                end else begin
                    rechazo_d = 1'b1;
                end
            end else begin
                if (ocupacion != 7'd0) begin
                    dec_d = 1'b1;
                    if (unidades_q == 4'd0) begin
                        unidades_d = 4'd9;
                        decenas_d  = decenas_q - 4'd1;
                    end else begin
                        unidades_d = unidades_q - 4'd1;
                    end
                end else begin
                    rechazo_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_btn) begin
            for (int i = 0; i < 4; i++) begin
                pend_q[i] <= 2'd0;
            end
            err_q      <= 1'b0;
            unidades_q <= 4'd0;
            decenas_q  <= 4'd0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            rechazo_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pend_q[i] <= pend_d[i];
            end
            err_q      <= err_d;
            unidades_q <= unidades_d;
            decenas_q  <= decenas_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            rechazo_q  <= rechazo_d;
        end
    end

    assign inc          = inc_q;
    assign dec          = dec_q;
    assign rechazo      = rechazo_q;
    assign err_desborde = err_q;
    assign unidades     = unidades_q;
    assign decenas      = decenas_q;
    assign lleno        = (ocupacion == Cap);
    assign vacio        = (ocupacion == 7'd0);

endmodule

// File: tb/tb_arbitro_de_ocupacion.sv
// Directed self-checking bench for arbitro_de_ocupacion (CAPACIDAD=12, PEND_MAX=3).
module tb_arbitro_de_ocupacion;

    logic       clk = 1'b0;
    logic       reset_btn = 1'b1;
    logic       ent_a = 1'b0;
    logic       sal_a = 1'b0;
    logic       ent_b = 1'b0;
    logic       sal_b = 1'b0;
    logic       inc;
    logic       dec;
    logic [3:0] unidades;
    logic [3:0] decenas;
    logic       lleno;
    logic       vacio;
    logic       rechazo;
    logic       err_desborde;

    int passed = 0;
    int total  = 0;

    arbitro_de_ocupacion #(
        .CAPACIDAD(12),
        .PEND_MAX (3)
    ) dut (
        .clk         (clk),
        .reset_btn   (reset_btn),
        .ent_a       (ent_a),
        .sal_a       (sal_a),
        .ent_b       (ent_b),
        .sal_b       (sal_b),
        .inc         (inc),
        .dec         (dec),
        .unidades    (unidades),
        .decenas     (decenas),
        .lleno       (lleno),
        .vacio       (vacio),
        .rechazo     (rechazo),
        .err_desborde(err_desborde)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ea, input logic sa, input logic eb, input logic sb);
        ent_a = ea;
        sal_a = sa;
        ent_b = eb;
        sal_b = sb;
    endtask

    task automatic do_reset();
        reset_btn = 1'b1;
        tick();
        reset_btn = 1'b0;
    endtask

    // One pulse, then wait for its update to be applied and settle.
    task automatic apply(input logic ea, input logic sa, input logic eb, input logic sb);
        drive(ea, sa, eb, sb);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_btn = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        reset_btn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if ({decenas, unidades} !== 8'h00) $display("FAIL rst_digits: got %h want 00", {decenas, unidades}); else passed++;
        total++; if ({inc, dec, rechazo, err_desborde} !== 4'b0000) $display("FAIL rst_pulses: got %b want 0000", {inc, dec, rechazo, err_desborde}); else passed++;
        total++; if ({vacio, lleno} !== 2'b10) $display("FAIL rst_status: got vacio/lleno %b want 10", {vacio, lleno}); else passed++;
        tick();
        total++; if ({inc, unidades} !== 5'b0_0000) $display("FAIL rst_drops_req: got inc/u %b want 00000", {inc, unidades}); else passed++;
    endtask

    task automatic test_latency();
        logic [3:0] n;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            n = 4'(k);
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            total++; if (inc !== 1'b0) $display("FAIL lat_early%0d: got inc %b want 0", k, inc); else passed++;
            tick();
            total++; if ({inc, unidades} !== {1'b1, n}) $display("FAIL lat_inc%0d: got inc/u %b/%0d want 1/%0d", k, inc, unidades, n); else passed++;
            tick();
            total++; if (inc !== 1'b0) $display("FAIL lat_onecycle%0d: got inc %b want 0", k, inc); else passed++;
            tick();
        end
        total++; if ({decenas, unidades, vacio} !== {4'd0, 4'd3, 1'b0}) $display("FAIL lat_final: got d/u/vacio %0d/%0d/%b want 0/3/0", decenas, unidades, vacio); else passed++;
    endtask

    task automatic test_same_cycle();
        logic [3:0] exp_u   [4];
        logic       exp_inc [4];
        logic       exp_dec [4];
`ifdef PRIORIDAD_SALIDA_EN
        exp_u   = '{4'd4, 4'd3, 4'd4, 4'd5};
        exp_inc = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_dec = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
        exp_u   = '{4'd6, 4'd5, 4'd6, 4'd5};
        exp_inc = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_dec = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        // Six entries then one sal_b: occupancy 5 with the pointer back at 0.
        do_reset();
        repeat (6) apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            tick();
            total++;
            if ({inc, dec, rechazo, unidades} !== {exp_inc[s], exp_dec[s], 1'b0, exp_u[s]})
                $display("FAIL same_cycle%0d: got inc/dec/rech/u %b/%b/%b/%0d want %b/%b/0/%0d",
                         s, inc, dec, rechazo, unidades, exp_inc[s], exp_dec[s], exp_u[s]);
            else passed++;
        end
        tick();
        total++; if ({inc, dec, unidades} !== {2'b00, 4'd5}) $display("FAIL same_idle: got inc/dec/u %b/%b/%0d want 0/0/5", inc, dec, unidades); else passed++;
    endtask

    task automatic test_full();
        do_reset();
        repeat (12) apply(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if ({decenas, unidades, lleno} !== {4'd1, 4'd2, 1'b1}) $display("FAIL full_reach: got d/u/lleno %0d/%0d/%b want 1/2/1", decenas, unidades, lleno); else passed++;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if ({rechazo, inc} !== 2'b10) $display("FAIL full_reject: got rech/inc %b/%b want 1/0", rechazo, inc); else passed++;
        total++; if ({decenas, unidades, lleno} !== {4'd1, 4'd2, 1'b1}) $display("FAIL full_hold: got d/u/lleno %0d/%0d/%b want 1/2/1", decenas, unidades, lleno); else passed++;
        tick();
        total++; if (rechazo !== 1'b0) $display("FAIL full_rech_pulse: got %b want 0", rechazo); else passed++;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if ({dec, decenas, unidades, lleno} !== {1'b1, 4'd1, 4'd1, 1'b0}) $display("FAIL full_exit: got dec/d/u/lleno %b/%0d/%0d/%b want 1/1/1/0", dec, decenas, unidades, lleno); else passed++;
        tick();
        // Two more exits cross the tens boundary downward: 11 -> 10 -> 9.
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if ({decenas, unidades} !== {4'd0, 4'd9}) $display("FAIL borrow: got d/u %0d/%0d want 0/9", decenas, unidades); else passed++;
    endtask

    task automatic test_empty();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if ({rechazo, dec} !== 2'b10) $display("FAIL empty_reject: got rech/dec %b/%b want 1/0", rechazo, dec); else passed++;
        total++; if ({decenas, unidades, vacio} !== {8'h00, 1'b1}) $display("FAIL empty_hold: got d/u/vacio %0d/%0d/%b want 0/0/1", decenas, unidades, vacio); else passed++;
        tick();
        total++; if (rechazo !== 1'b0) $display("FAIL empty_rech_pulse: got %b want 0", rechazo); else passed++;
    endtask

`ifndef PRIORIDAD_SALIDA_EN
    task automatic test_overflow();
        // One entry first leaves the pointer at 1, so ent_a waits behind sources 1..3.
        do_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if ({dec, unidades} !== {1'b1, 4'd0}) $display("FAIL ovf_sal_a: got dec/u %b/%0d want 1/0", dec, unidades); else passed++;
        tick();
        total++; if (err_desborde !== 1'b0) $display("FAIL ovf_early: got %b want 0", err_desborde); else passed++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (err_desborde !== 1'b1) $display("FAIL ovf_set: got %b want 1", err_desborde); else passed++;
        repeat (6) tick();
        total++; if ({err_desborde, decenas, unidades} !== {1'b1, 4'd0, 4'd3}) $display("FAIL ovf_final: got err/d/u %b/%0d/%0d want 1/0/3", err_desborde, decenas, unidades); else passed++;
    endtask
`else
    task automatic test_prioridad();
        do_reset();
        repeat (12) apply(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if ({dec, inc, decenas, unidades} !== {2'b10, 4'd1, 4'd1}) $display("FAIL prio_exit: got dec/inc/d/u %b/%b/%0d/%0d want 1/0/1/1", dec, inc, decenas, unidades); else passed++;
        tick();
        total++; if ({inc, rechazo, decenas, unidades} !== {2'b10, 4'd1, 4'd2}) $display("FAIL prio_entry: got inc/rech/d/u %b/%b/%0d/%0d want 1/0/1/2", inc, rechazo, decenas, unidades); else passed++;
    endtask
`endif

    task automatic test_reset_mid_burst();
        do_reset();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset_btn = 1'b1;
        tick();
        reset_btn = 1'b0;
        total++; if ({decenas, unidades, inc, dec, vacio} !== {8'h00, 3'b001}) $display("FAIL mid_rst: got d/u/inc/dec/vacio %0d/%0d/%b/%b/%b want 0/0/0/0/1", decenas, unidades, inc, dec, vacio); else passed++;
        for (int s = 0; s < 4; s++) begin
            tick();
            total++; if ({inc, dec, rechazo, unidades} !== 7'd0) $display("FAIL mid_rst_drop%0d: got inc/dec/rech/u %b/%b/%b/%0d want 0/0/0/0", s, inc, dec, rechazo, unidades); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_same_cycle();
        test_full();
        test_empty();
`ifndef PRIORIDAD_SALIDA_EN
        test_overflow();
`else
        test_prioridad();
`endif
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arbitro_de_ocupacion.md
# arbitro_de_ocupacion

Arbitration and sequencing controller for the shared occupancy counter of the multi-lane car-park design. Two lanes (A, B) each run their own debounced sensor FSM and emit single-cycle entry/exit pulses. This block buffers those pulses per source and grants exactly one counter update per cycle. It keeps the BCD occupancy (0..CAPACIDAD) and drives full/empty/reject status for the display and barrier logic.

## Interface
Parameters:
- CAPACIDAD, 99: maximum occupancy, binary, legal range 1..99.
- PEND_MAX, 3: saturation value of each per-source pending counter, 2-bit, legal range 1..3.

Ports:
- clk  in  1  system clock (100 MHz on board).
- reset_btn  in  1  reset; synchronous, active-high.
- ent_a, sal_a, ent_b, sal_b  in  1 each  single-cycle request pulses from the lane FSMs.
- inc  out  1  one-cycle pulse: a granted entry was applied.
- dec  out  1  one-cycle pulse: a granted exit was applied.
- unidades  out  4  occupancy units digit, BCD.
- decenas  out  4  occupancy tens digit, BCD.
- lleno  out  1  high while occupancy == CAPACIDAD.
- vacio  out  1  high while occupancy == 0.
- rechazo  out  1  one-cycle pulse: a granted request was dropped (entry while full, or exit while empty).
- err_desborde  out  1  sticky; set when a request arrives at a source whose pending count is PEND_MAX.

## Operation
- Source index order: 0 = ent_a, 1 = sal_a, 2 = ent_b, 3 = sal_b.
- Each source has a pending counter pend[i] in 0..PEND_MAX.
- Per-edge update of pend[i]:
  - request and no grant: +1, saturating at PEND_MAX.
  - grant and no request: -1.
  - request and grant in the same cycle: unchanged.
  - request at PEND_MAX with no grant: count is lost, err_desborde sets.
- Round-robin pointer ptr (2 bits):
  - Grant goes to the first i with pend[i] != 0, searching ptr, ptr+1, … mod 4.
  - After a grant, ptr = granted index + 1 mod 4.
  - ptr is unchanged when nothing is granted.
  - At most one grant per cycle.
- Granted entry:
  - occupancy < CAPACIDAD: occupancy +1, inc=1.
  - otherwise: no change, rechazo=1.
- Granted exit:
  - occupancy > 0: occupancy -1, dec=1.
  - otherwise: no change, rechazo=1.
- BCD arithmetic:
  - Increment: unidades 9→0 with decenas +1.
  - Decrement: unidades 0→9 with decenas -1.
  - decenas never exceeds 9. Occupancy never goes outside 0..CAPACIDAD.
- lleno and vacio are decoded combinationally from the registered digits.
- err_desborde clears only on reset.

## Timing
- Reset values (synchronous reset_btn=1 at an edge):
  - pend = 0, ptr = 0, unidades = decenas = 0.
  - inc = dec = rechazo = err_desborde = 0.
  - vacio = 1, lleno = 0.
- Reset overrides any request present in the same cycle; requests in flight are discarded.
- Request latency:
  - A pulse present before edge k sets pend after edge k.
  - The grant is evaluated in cycle k and registered at edge k+1.
  - After edge k+1: inc/dec/rechazo are high for exactly one cycle, and the digits already hold the new value.
  - Minimum request→inc latency: 2 edges. Throughput: one update per cycle.
- Worst case: a source waits at most 3 grants of other sources (round-robin mode).
- All four sources pulsing in the same cycle:
  - Grants issue over 4 consecutive cycles in ptr order.
  - The net occupancy change equals entries applied minus exits applied.

## Configuration
- PRIORIDAD_SALIDA_EN:
  - Defined: fixed priority sal_a > sal_b > ent_a > ent_b. ptr is unused. Exits are always served first, so they free space before queued entries are tested against lleno.
  - Undefined: round-robin as described above.

## Test plan
- Reset, then 3 ent_a pulses 4 cycles apart → 3 inc pulses, each 2 edges after its request; digits 0/3; vacio=0.
- Same-cycle ent_a, sal_a, ent_b, sal_b from occupancy 5, round-robin, ptr=0 → grants in order 0,1,2,3 on consecutive cycles; occupancy 6,5,6,5; no rechazo.
- Occupancy preset via entries to CAPACIDAD=12, then ent_b → rechazo pulse, digits stay 1/2, lleno=1; then sal_a → dec, occupancy 11, lleno=0.
- From reset, sal_b → rechazo pulse, occupancy 0, vacio stays 1.
- 4 ent_a pulses on consecutive cycles with ent_b and sal_b kept busy (PEND_MAX=3) → err_desborde=1 and stays set; only the buffered requests are applied.
- PRIORIDAD_SALIDA_EN defined, occupancy 99, CAPACIDAD=99, ent_a and sal_a in the same cycle → dec first (98), then inc (99), no rechazo; reset_btn asserted mid-burst → all pending dropped, digits 0/0 after that edge.
